bram_stream_reader: RTL
=======================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, BRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, BRAM word width.
REQ-003 SHALL have parameter LEN_WIDTH, default ADDR_WIDTH+1, transfer-length width (allows a full DEPTH transfer).
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 SHALL have ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer.
- base_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  LEN_WIDTH  word count, sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable, constant 0.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_din  out  DATA_WIDTH  BRAM write data, constant 0.
- bram_dout  in  DATA_WIDTH  BRAM read data, valid one cycle after bram_en.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  marks the final word of a transfer.
- m_ready  in  1  stream consumer ready.

Function
REQ-006 SHALL implement states IDLE, READ and DRAIN.
REQ-007 In IDLE, start=1 SHALL latch base_addr and length.
- length>0: go to READ.
- length==0: go to IDLE, pulse done the next cycle, issue no reads.
REQ-008 start while busy=1 SHALL be ignored with no effect on the transfer in progress.
REQ-009 A read issue SHALL be a cycle with bram_en=1, bram_we=0 and bram_addr=(base_addr+i) mod 2^ADDR_WIDTH, for i=0..length-1 in order.
- Address wraps from 2^ADDR_WIDTH-1 to 0.
REQ-010 bram_dout SHALL be captured exactly one cycle after each issue cycle, into a 2-entry output FIFO.
REQ-011 A read SHALL issue only when (FIFO occupancy + reads in flight - pop this cycle) < 2, so the FIFO never overflows.
REQ-012 With m_ready held at 1, the block SHALL sustain one word per cycle after the first word.
- First m_valid SHALL assert 2 cycles after the start cycle.
REQ-013 m_valid SHALL present the FIFO head.
- Once m_valid=1, m_valid, m_data and m_last SHALL hold stable until m_valid&&m_ready.
REQ-014 A word SHALL be consumed only in a cycle with m_valid&&m_ready.
REQ-015 m_last SHALL be 1 only with the word of index length-1.
REQ-016 When the last read issues, the state SHALL go READ->DRAIN. No further bram_en in DRAIN.
REQ-017 In DRAIN, acceptance of the m_last word SHALL return the state to IDLE and pulse done=1 the next cycle, with busy=0 in that cycle.
REQ-018 bram_en SHALL be 0 in every cycle with no read issue.
REQ-019 Simultaneous FIFO push and pop SHALL leave occupancy unchanged and preserve order.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force the following, at any time including mid-transfer:
- state=IDLE, FIFO empty, in-flight count 0.
- busy=0, done=0, bram_en=0, bram_addr=0, m_valid=0, m_data=0, m_last=0.
REQ-021 bram_dout returning after a reset SHALL be discarded.
REQ-022 A start on the first cycle after reset release SHALL be accepted.

Verification
REQ-023 Bench SHALL cover:
- Basic: mem[i]=0x1000+i, base=4, len=4, m_ready=1 -> m_data 0x1004..0x1007 on consecutive cycles; m_last on 0x1007; done 1 cycle later; bram_en high 4 cycles.
- Wrap: base=1022, len=4 -> bram_addr 1022,1023,0,1 in order.
- Backpressure: len=8, m_ready toggling 1,0,0,1,... -> all 8 words in order; data held while stalled; never more than 2 reads outstanding plus buffered.
- Zero length: start with len=0 -> no bram_en; done pulses 1 cycle after start.
- Reset mid-transfer: rst_n=0 after 3 of 8 words -> all outputs 0 next cycle; a new start with base=0, len=2 then gives mem[0], mem[1] only.
- Start while busy: second start with base=100 during len=6 transfer -> ignored; exactly 6 words; single done.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a block of words out of a synchronous-read BRAM.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   start, base_addr, length   transfer request, sampled together in IDLE
//   busy, done                 transfer in progress / one-cycle completion pulse
//   bram_en, bram_we,
//   bram_addr, bram_din        BRAM port (read-only; we and din tied to 0)
//   bram_dout                  BRAM read data, one cycle after bram_en
//   m_valid, m_data, m_last,
//   m_ready                    output stream with ready/valid handshake
module bram_stream_reader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  rem_q;
   logic                  infl_q;
   logic                  infl_last_q;
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic [1:0]            fifo_last;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            cnt_q;
   logic                  launch;
   logic                  pop;
   logic                  issue;
   logic                  issue_last;
   logic [2:0]            room;
   // The first read is issued in the start cycle itself so the first word
   // reaches the stream two cycles after start; the issue decision must also
   // see this cycle's pop, so it is combinational.
   always_comb begin
      launch     = state == IDLE && start && length != '0;
      pop        = m_valid && m_ready;
      room       = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
      issue      = rst_n && (launch || state == READ) && room < 3'd2;
      issue_last = launch ? length == LEN_WIDTH'(1) : rem_q == LEN_WIDTH'(1);
   end
   assign busy      = state != IDLE;
   assign bram_en   = issue;
   assign bram_we   = 1'b0;
   assign bram_din  = '0;
   assign bram_addr = issue ? (launch ? base_addr : addr_q) : '0;
   assign m_valid   = cnt_q != 2'd0;
   assign m_data    = m_valid ? fifo_data[rd_ptr] : '0;
   assign m_last    = m_valid && fifo_last[rd_ptr];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         infl_q       <= 1'b0;
         infl_last_q  <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last    <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         cnt_q        <= '0;
         done         <= 1'b0;
      end else begin
         done        <= 1'b0;
         infl_q      <= issue;
         infl_last_q <= issue && issue_last;
         // infl_q marks the cycle in which bram_dout carries the last issue's word
         if (infl_q) begin
            fifo_data[wr_ptr] <= bram_dout;
            fifo_last[wr_ptr] <= infl_last_q;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         cnt_q <= cnt_q + 2'(infl_q) - 2'(pop);
         case (state)
            IDLE:
               if (start && length == '0)
                  done <= 1'b1;
               else if (issue) begin
                  addr_q <= base_addr + ADDR_WIDTH'(1);
                  rem_q  <= length - LEN_WIDTH'(1);
                  state  <= issue_last ? DRAIN : READ;
               end
            READ:
               if (issue) begin
                  addr_q <= addr_q + ADDR_WIDTH'(1);
                  rem_q  <= rem_q - LEN_WIDTH'(1);
                  if (issue_last)
                     state <= DRAIN;
               end
            DRAIN:
               if (pop && m_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            default:
               state <= IDLE;
         endcase
      end
   end
endmodule
